mul_div_ctrl: RTL

//   Multi-cycle controller for the CPU's MUL/DIV unit. It sequences the combinational
//   bit-pair Booth multiplier (bp_booth_mul_32) as a multicycle path. It also runs an

---
 rtl/mul_div_ctrl_if.sv | 23 ++
 rtl/mul_div_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mul_div_ctrl_if.sv
// Handshake and result bundle between the control unit and the MUL/DIV controller.
interface mul_div_ctrl_if;
    logic        start;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic        ready;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_by_zero;

    modport master (
        output start, op, a, b,
        input  ready, busy, done, hi, lo, div_by_zero
    );

    modport slave (
        input  start, op, a, b,
        output ready, busy, done, hi, lo, div_by_zero
    );
endinterface

// File: rtl/mul_div_ctrl.sv
// MUL/DIV unit: combinational radix-4 Booth multiplier run as a multicycle path,
// plus a 32-step restoring signed divider, sequenced by one controller FSM.

module bp_booth_mul_32 (
    input  logic [31:0] i_x,
    input  logic [31:0] i_y,
    output logic [63:0] o_z
);
    logic [32:0]        w_yext;
    logic signed [63:0] w_x64;
    logic signed [63:0] w_pp;
    logic signed [63:0] w_acc;
    logic [2:0]         w_sel;

    // Each overlapping 3-bit window of y selects 0, +-x or +-2x.
    always_comb begin
        w_yext = {i_y, 1'b0};
        w_x64  = {{32{i_x[31]}}, i_x};
        w_acc  = '0;
        w_pp   = '0;
        w_sel  = '0;
        for (int i = 0; i < 16; i++) begin
            w_sel = w_yext[2*i +: 3];
            case (w_sel)
                3'b001, 3'b010: w_pp = w_x64;
                3'b011:         w_pp = w_x64 <<< 1;
                3'b100:         w_pp = -(w_x64 <<< 1);
                3'b101, 3'b110: w_pp = -w_x64;
                default:        w_pp = '0;
            endcase
            w_acc = w_acc + (w_pp <<< (2 * i));
        end
        o_z = w_acc;
    end
endmodule

module mul_div_ctrl #(
    parameter int unsigned MUL_CYCLES = 2
) (
    input  logic           clk,
    input  logic           clr,
    mul_div_ctrl_if.slave  bus
);
    localparam int unsigned W     = 32;
    localparam int unsigned CNT_W = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL_WAIT,
        S_DIV_RUN,
        S_DIV_FIX,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [W-1:0]     r_opa;     // multiplicand, or dividend shifting into quotient
    logic [W-1:0]     r_opb;     // multiplier, or |divisor|
    logic [W-1:0]     r_rem;
    logic             r_q_neg;
    logic             r_r_neg;
    logic [W-1:0]     r_hi;
    logic [W-1:0]     r_lo;
    logic             r_done;
    logic             r_dbz;
    logic             r_ready;
    logic             r_busy;

    logic             w_accept;
    logic [W-1:0]     w_abs_a;
    logic [W-1:0]     w_abs_b;
    logic [W:0]       w_shift;
    logic [W:0]       w_diff;
    logic             w_ge;
    logic [2*W-1:0]   w_prod;

    bp_booth_mul_32 u_mul (
        .i_x (r_opa),
        .i_y (r_opb),
        .o_z (w_prod)
    );

    assign w_accept = bus.start & r_ready;
    // Magnitude of 0x80000000 stays 0x80000000, read as unsigned 2^31.
    assign w_abs_a  = bus.a[W-1] ? W'(-bus.a) : bus.a;
    assign w_abs_b  = bus.b[W-1] ? W'(-bus.b) : bus.b;

    // One restoring step: bring in the next dividend bit, try subtracting the divisor.
    assign w_shift  = {r_rem, r_opa[W-1]};
    assign w_diff   = w_shift - {1'b0, r_opb};
    assign w_ge     = ~w_diff[W];

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_opa   <= '0;
            r_opb   <= '0;
            r_rem   <= '0;
            r_q_neg <= 1'b0;
            r_r_neg <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_done  <= 1'b0;
            r_dbz   <= 1'b0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    if (w_accept) begin
                        r_dbz <= 1'b0;
                        if (!bus.op) begin
                            r_opa   <= bus.a;
                            r_opb   <= bus.b;
                            r_cnt   <= CNT_W'(MUL_CYCLES - 1);
                            r_state <= S_MUL_WAIT;
                            r_ready <= 1'b0;
                            r_busy  <= 1'b1;
                        end else if (bus.b == '0) begin
                            r_hi    <= bus.a;
                            r_lo    <= '1;
                            r_dbz   <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_opa   <= w_abs_a;
                            r_opb   <= w_abs_b;
                            r_rem   <= '0;
                            r_q_neg <= bus.a[W-1] ^ bus.b[W-1];
                            r_r_neg <= bus.a[W-1];
                            r_cnt   <= CNT_W'(W - 1);
                            r_state <= S_DIV_RUN;
                            r_ready <= 1'b0;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                S_MUL_WAIT: begin
                    if (r_cnt == '0) begin
                        {r_hi, r_lo} <= w_prod;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_DIV_RUN: begin
                    r_rem <= w_ge ? w_diff[W-1:0] : w_shift[W-1:0];
                    r_opa <= {r_opa[W-2:0], w_ge};
                    if (r_cnt == '0) begin
                        r_state <= S_DIV_FIX;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_DIV_FIX: begin
                    // Quotient truncates toward zero; remainder follows the dividend sign.
                    r_lo    <= r_q_neg ? W'(-r_opa) : r_opa;
                    r_hi    <= r_r_neg ? W'(-r_rem) : r_rem;
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ready       = r_ready;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.hi          = r_hi;
    assign bus.lo          = r_lo;
    assign bus.div_by_zero = r_dbz;
endmodule
